// File: rtl/ysyx_25010008_pkg.sv
// ysyx_25010008_pkg: RV32I encodings, CSR addresses, ALU/writeback/next-PC selects and the reset vector
package ysyx_25010008_pkg;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_ADD   = 3'd0;
  localparam logic [2:0] F3_SLL   = 3'd1;
  localparam logic [2:0] F3_SLT   = 3'd2;
  localparam logic [2:0] F3_SLTU  = 3'd3;
  localparam logic [2:0] F3_XOR   = 3'd4;
  localparam logic [2:0] F3_SR    = 3'd5;
  localparam logic [2:0] F3_OR    = 3'd6;
  localparam logic [2:0] F3_CSRRW = 3'd1;
  localparam logic [2:0] F3_CSRRS = 3'd2;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef enum logic [2:0] {WB_NONE, WB_ALU, WB_IMM, WB_PC4, WB_MEM, WB_CSR} wb_sel_e;
  typedef enum logic [2:0] {NPC_SEQ, NPC_JAL, NPC_BR, NPC_JALR, NPC_CSR} npc_sel_e;
  // sub_ok is set only for register-register ops, where funct7[5] selects SUB
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt, input logic sub_ok);
    return f3 == F3_ADD  ? ((alt && sub_ok) ? ALU_SUB : ALU_ADD) :
           f3 == F3_SLL  ? ALU_SLL :
           f3 == F3_SLT  ? ALU_SLT :
           f3 == F3_SLTU ? ALU_SLTU :
           f3 == F3_XOR  ? ALU_XOR :
           f3 == F3_SR   ? (alt ? ALU_SRA : ALU_SRL) :
           f3 == F3_OR   ? ALU_OR : ALU_AND;
  endfunction
endpackage

// File: rtl/ysyx_25010008_fetch_exec_if.sv
// ysyx_25010008_fetch_exec_if: datapath bus to PC owner, register/CSR heap and data memory
interface ysyx_25010008_fetch_exec_if;
  logic [31:0] pc, imem_addr, imem_rdata, src1, src2, r_wdata, csr_src, csr_wdata1, csr_wdata2;
  logic [31:0] alu_result, mem_rdata, npc;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] csr_s, csr_d1, csr_d2;
  logic        r_wen, csr_wen1, csr_wen2, mem_ren, mem_wen, suffix_b, suffix_h, sext, halt;
  modport master (
    input  pc, imem_rdata, src1, src2, csr_src, mem_rdata,
    output imem_addr, rs1, rs2, rd, r_wen, r_wdata, csr_s, csr_d1, csr_d2, csr_wen1, csr_wen2,
           csr_wdata1, csr_wdata2, mem_ren, mem_wen, suffix_b, suffix_h, sext, alu_result, npc, halt
  );
  modport slave (
    output pc, imem_rdata, src1, src2, csr_src, mem_rdata,
    input  imem_addr, rs1, rs2, rd, r_wen, r_wdata, csr_s, csr_d1, csr_d2, csr_wen1, csr_wen2,
           csr_wdata1, csr_wdata2, mem_ren, mem_wen, suffix_b, suffix_h, sext, alu_result, npc, halt
  );
endinterface

// File: rtl/ysyx_25010008_alu.sv
// ysyx_25010008_alu: RV32I integer ALU
module ysyx_25010008_alu
  import ysyx_25010008_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y
);
  always_comb
    y = op == ALU_SUB  ? a - b :
        op == ALU_SLL  ? a << b[4:0] :
        op == ALU_SLT  ? {31'b0, $signed(a) < $signed(b)} :
        op == ALU_SLTU ? {31'b0, a < b} :
        op == ALU_XOR  ? a ^ b :
        op == ALU_SRL  ? a >> b[4:0] :
        op == ALU_SRA  ? $unsigned($signed(a) >>> b[4:0]) :
        op == ALU_OR   ? a | b :
        op == ALU_AND  ? a & b : a + b;
endmodule

// File: rtl/ysyx_25010008_fetch_exec.sv
// ysyx_25010008_fetch_exec: single-cycle RV32I fetch/decode/execute with sticky halt
// Zicsr (CSRRW/CSRRS/ECALL/MRET) is enabled by defining YSYX_25010008_ZICSR_EN.
module ysyx_25010008_fetch_exec
  import ysyx_25010008_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ysyx_25010008_pkg::RESET_PC
)(
  input logic clk,
  input logic rst,
  ysyx_25010008_fetch_exec_if.master bus
);
  logic [31:0] inst, imm, imm_i, imm_s, imm_b, imm_u, imm_j, alu_a, alu_b, alu_y, pc4;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic        ill, use_alu, ecall, mret, csrrw, csrrs, en, hold, halt_q, taken, ls;
  alu_op_e     aop;
  wb_sel_e     wb;
  npc_sel_e    ns;
  assign inst  = bus.imem_rdata;
  assign op    = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  always_comb begin
    ill = 1'b0; imm = 32'b0; aop = ALU_ADD; wb = WB_NONE; ns = NPC_SEQ; use_alu = 1'b0;
    ecall = 1'b0; mret = 1'b0; csrrw = 1'b0; csrrs = 1'b0;
    case (op)
      OP_LUI:    begin imm = imm_u; wb = WB_IMM; end
      OP_AUIPC:  begin imm = imm_u; wb = WB_ALU; use_alu = 1'b1; end
      OP_JAL:    begin imm = imm_j; wb = WB_PC4; ns = NPC_JAL; end
      OP_JALR:   begin imm = imm_i; wb = WB_PC4; ns = NPC_JALR; ill = f3 != F3_ADD; end
      OP_BRANCH: begin imm = imm_b; ns = NPC_BR; ill = f3[2:1] == 2'b01; end
      OP_LOAD:   begin imm = imm_i; wb = WB_MEM; use_alu = 1'b1; ill = f3 == 3'd3 || f3 > 3'd5; end
      OP_STORE:  begin imm = imm_s; use_alu = 1'b1; ill = f3 > 3'd2; end
      OP_IMM: begin
        imm = imm_i; wb = WB_ALU; use_alu = 1'b1; aop = alu_dec(f3, f7[5], 1'b0);
        ill = (f3 == F3_SLL && f7 != F7_BASE) || (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
      end
      OP_REG: begin
        wb = WB_ALU; use_alu = 1'b1; aop = alu_dec(f3, f7[5], 1'b1);
        ill = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
      end
      OP_FENCE:  ill = f3 != F3_ADD;
      OP_SYSTEM: begin
`ifdef YSYX_25010008_ZICSR_EN
        ecall = inst == INST_ECALL;
        mret  = inst == INST_MRET;
        csrrw = f3 == F3_CSRRW;
        csrrs = f3 == F3_CSRRS;
        wb    = (csrrw || csrrs) ? WB_CSR : WB_NONE;
        ns    = (ecall || mret) ? NPC_CSR : NPC_SEQ;
`endif
        // EBREAK falls through here as illegal: both stop the core
        ill = !(ecall || mret || csrrw || csrrs);
      end
      default: ill = 1'b1;
    endcase
  end
  assign alu_a = op == OP_AUIPC ? bus.pc : bus.src1;
  assign alu_b = op == OP_REG ? bus.src2 : imm;
  ysyx_25010008_alu u_alu (.a(alu_a), .b(alu_b), .op(aop), .y(alu_y));
  assign taken = (f3[2] ? (f3[1] ? bus.src1 < bus.src2 : $signed(bus.src1) < $signed(bus.src2))
                        : bus.src1 == bus.src2) ^ f3[0];
  assign pc4  = bus.pc + 32'd4;
  assign hold = ill || halt_q;
  assign en   = rst && !hold;
  assign ls   = op == OP_LOAD || op == OP_STORE;
  assign bus.imem_addr  = bus.pc;
  assign bus.rs1        = inst[19:15];
  assign bus.rs2        = inst[24:20];
  assign bus.rd         = inst[11:7];
  assign bus.r_wen      = en && wb != WB_NONE;
  assign bus.r_wdata    = wb == WB_IMM ? imm :
                          wb == WB_PC4 ? pc4 :
                          wb == WB_MEM ? bus.mem_rdata :
                          wb == WB_CSR ? bus.csr_src :
                          wb == WB_ALU ? alu_y : 32'b0;
  assign bus.alu_result = use_alu ? alu_y : 32'b0;
  assign bus.mem_ren    = en && op == OP_LOAD;
  assign bus.mem_wen    = en && op == OP_STORE;
  assign bus.suffix_b   = ls && f3[1:0] == 2'd0;
  assign bus.suffix_h   = ls && f3[1:0] == 2'd1;
  assign bus.sext       = op == OP_LOAD && f3[2:1] == 2'd0;
  assign bus.npc        = hold ? bus.pc :
                          (ns == NPC_JAL || (ns == NPC_BR && taken)) ? bus.pc + imm :
                          ns == NPC_JALR ? {alu_y[31:1], 1'b0} :
                          ns == NPC_CSR ? bus.csr_src : pc4;
`ifdef YSYX_25010008_ZICSR_EN
  assign bus.csr_s      = ecall ? CSR_MTVEC : mret ? CSR_MEPC : (csrrw || csrrs) ? inst[31:20] : 12'h0;
  assign bus.csr_d1     = ecall ? CSR_MEPC : (csrrw || csrrs) ? inst[31:20] : 12'h0;
  assign bus.csr_d2     = ecall ? CSR_MCAUSE : 12'h0;
  assign bus.csr_wen1   = en && (ecall || csrrw || csrrs);
  assign bus.csr_wen2   = en && ecall;
  assign bus.csr_wdata1 = ecall ? bus.pc : csrrw ? bus.src1 : csrrs ? (bus.csr_src | bus.src1) : 32'b0;
  assign bus.csr_wdata2 = ecall ? 32'd11 : 32'b0;
`else
  assign bus.csr_s      = 12'h0;
  assign bus.csr_d1     = 12'h0;
  assign bus.csr_d2     = 12'h0;
  assign bus.csr_wen1   = 1'b0;
  assign bus.csr_wen2   = 1'b0;
  assign bus.csr_wdata1 = 32'b0;
  assign bus.csr_wdata2 = 32'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) halt_q <= 1'b0;
    else if (ill) halt_q <= 1'b1;
  assign bus.halt = halt_q;
endmodule

// File: tb/tb_ysyx_25010008_fetch_exec.sv
// tb_ysyx_25010008_fetch_exec: directed vector table plus halt/reset/CSR sequences
module tb_ysyx_25010008_fetch_exec;
  import ysyx_25010008_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int nvec = 0;
  int nerr = 0;
  ysyx_25010008_fetch_exec_if bus();
  ysyx_25010008_fetch_exec dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string n;
    logic [31:0] inst, pc, s1, s2, wen, rd, wd, npc, ren, mwen, sb, sh, sx, ca, alu;
  } vec_t;
  vec_t v[16];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    bus.imem_rdata = i; bus.pc = p; bus.src1 = a; bus.src2 = b;
  endtask
  task automatic quiet(input string n);
    chk({n, "_rwen"}, 32'(bus.r_wen), 0);
    chk({n, "_mren"}, 32'(bus.mem_ren), 0);
    chk({n, "_mwen"}, 32'(bus.mem_wen), 0);
    chk({n, "_cwen1"}, 32'(bus.csr_wen1), 0);
    chk({n, "_cwen2"}, 32'(bus.csr_wen2), 0);
  endtask
  task automatic reset_pulse();
    @(negedge clk); rst = 1'b0;
    #1 chk("rstp_halt", 32'(bus.halt), 0);
    @(negedge clk); rst = 1'b1;
  endtask
  initial begin
    //        name     inst          pc            src1          src2          wen rd  wdata         npc           ren mw sb sh sx ca alu
    v[0]  = '{"addi",  32'h00500093, 32'h80000000, 32'h0,        32'h0,        1, 1,  32'h5,        32'h80000004, 0, 0, 0, 0, 0, 1, 32'h5};
    v[1]  = '{"beq_t", 32'h00208463, 32'h80000000, 32'h7,        32'h7,        0, 8,  32'h0,        32'h80000008, 0, 0, 0, 0, 0, 0, 32'h0};
    v[2]  = '{"beq_n", 32'h00208463, 32'h80000000, 32'h7,        32'h8,        0, 8,  32'h0,        32'h80000004, 0, 0, 0, 0, 0, 0, 32'h0};
    v[3]  = '{"lw",    32'h0040A103, 32'h80000000, 32'h80001000, 32'h0,        1, 2,  32'hDEADBEEF, 32'h80000004, 1, 0, 0, 0, 0, 1, 32'h80001004};
    v[4]  = '{"jalr",  32'h000280E7, 32'h80000010, 32'h80000103, 32'h0,        1, 1,  32'h80000014, 32'h80000102, 0, 0, 0, 0, 0, 0, 32'h0};
    v[5]  = '{"sub",   32'h402081B3, 32'h80000000, 32'd10,       32'd3,        1, 3,  32'd7,        32'h80000004, 0, 0, 0, 0, 0, 1, 32'd7};
    v[6]  = '{"srai",  32'h4040D213, 32'h80000000, 32'h80000000, 32'h0,        1, 4,  32'hF8000000, 32'h80000004, 0, 0, 0, 0, 0, 1, 32'hF8000000};
    v[7]  = '{"sltu",  32'h0020B2B3, 32'h80000000, 32'h1,        32'hFFFFFFFF, 1, 5,  32'h1,        32'h80000004, 0, 0, 0, 0, 0, 1, 32'h1};
    v[8]  = '{"lui",   32'h12345337, 32'h80000000, 32'h0,        32'h0,        1, 6,  32'h12345000, 32'h80000004, 0, 0, 0, 0, 0, 0, 32'h0};
    v[9]  = '{"auipc", 32'h00001397, 32'h80000000, 32'h0,        32'h0,        1, 7,  32'h80001000, 32'h80000004, 0, 0, 0, 0, 0, 1, 32'h80001000};
    v[10] = '{"jal",   32'hFFDFF0EF, 32'h80000100, 32'h0,        32'h0,        1, 1,  32'h80000104, 32'h800000FC, 0, 0, 0, 0, 0, 0, 32'h0};
    v[11] = '{"sb",    32'h002081A3, 32'h80000000, 32'h100,      32'h55,       0, 3,  32'h0,        32'h80000004, 0, 1, 1, 0, 0, 1, 32'h103};
    v[12] = '{"lh",    32'hFFE09103, 32'h80000000, 32'h200,      32'h0,        1, 2,  32'hDEADBEEF, 32'h80000004, 1, 0, 0, 1, 1, 1, 32'h1FE};
    v[13] = '{"blt",   32'h0020C863, 32'h80000000, 32'hFFFFFFFF, 32'h1,        0, 16, 32'h0,        32'h80000010, 0, 0, 0, 0, 0, 0, 32'h0};
    v[14] = '{"bltu",  32'h0020E863, 32'h80000000, 32'hFFFFFFFF, 32'h1,        0, 16, 32'h0,        32'h80000004, 0, 0, 0, 0, 0, 0, 32'h0};
    v[15] = '{"fence", 32'h0000000F, 32'h80000000, 32'h0,        32'h0,        0, 0,  32'h0,        32'h80000004, 0, 0, 0, 0, 0, 0, 32'h0};
    bus.mem_rdata = 32'hDEADBEEF;
    bus.csr_src   = 32'h12345678;
    drive(32'h00500093, 32'h80000000, 0, 0);
    #1;
    chk("rst_halt", 32'(bus.halt), 0);
    quiet("rst");
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      drive(v[k].inst, v[k].pc, v[k].s1, v[k].s2);
      #2;
      chk({v[k].n, "_wen"}, 32'(bus.r_wen), v[k].wen);
      chk({v[k].n, "_rd"}, 32'(bus.rd), v[k].rd);
      chk({v[k].n, "_npc"}, bus.npc, v[k].npc);
      chk({v[k].n, "_mren"}, 32'(bus.mem_ren), v[k].ren);
      chk({v[k].n, "_mwen"}, 32'(bus.mem_wen), v[k].mwen);
      chk({v[k].n, "_sb"}, 32'(bus.suffix_b), v[k].sb);
      chk({v[k].n, "_sh"}, 32'(bus.suffix_h), v[k].sh);
      chk({v[k].n, "_sext"}, 32'(bus.sext), v[k].sx);
      chk({v[k].n, "_cwen"}, 32'(bus.csr_wen1), 0);
      if (v[k].wen) chk({v[k].n, "_wdata"}, bus.r_wdata, v[k].wd);
      if (v[k].ca) chk({v[k].n, "_alu"}, bus.alu_result, v[k].alu);
    end
    chk("imem_addr", bus.imem_addr, 32'h80000000);
    chk("lw_rs1", 32'(bus.rs1), 0);
    @(posedge clk); #1 chk("legal_nohalt", 32'(bus.halt), 0);
    @(negedge clk); drive(INST_EBREAK, 32'h80000040, 0, 0);
    #1;
    quiet("brk");
    chk("brk_npc", bus.npc, 32'h80000040);
    chk("brk_halt_pre", 32'(bus.halt), 0);
    @(posedge clk); #1 chk("brk_halt_post", 32'(bus.halt), 1);
    @(negedge clk); drive(32'h00000013, 32'h80000044, 0, 0);
    #1;
    chk("halt_sticky", 32'(bus.halt), 1);
    quiet("halted");
    chk("halted_npc", bus.npc, 32'h80000044);
    @(posedge clk); #1 chk("halt_sticky2", 32'(bus.halt), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_clr", 32'(bus.halt), 0);
    quiet("inrst");
    @(negedge clk); rst = 1'b1;
    #1;
    chk("nop_wen", 32'(bus.r_wen), 1);
    chk("nop_npc", bus.npc, 32'h80000048);
    @(posedge clk); #1 chk("nop_nohalt", 32'(bus.halt), 0);
    @(negedge clk); drive(32'hFFFFFFFF, 32'h80000050, 0, 0);
    #1;
    quiet("ill");
    chk("ill_npc", bus.npc, 32'h80000050);
    @(posedge clk); #1 chk("ill_halt", 32'(bus.halt), 1);
    reset_pulse();
`ifdef YSYX_25010008_ZICSR_EN
    bus.csr_src = 32'h80000100;
    drive(INST_ECALL, 32'h80000020, 0, 0);
    #1;
    chk("ecall_wen1", 32'(bus.csr_wen1), 1);
    chk("ecall_wen2", 32'(bus.csr_wen2), 1);
    chk("ecall_d1", 32'(bus.csr_d1), 32'h341);
    chk("ecall_wd1", bus.csr_wdata1, 32'h80000020);
    chk("ecall_d2", 32'(bus.csr_d2), 32'h342);
    chk("ecall_wd2", bus.csr_wdata2, 32'd11);
    chk("ecall_s", 32'(bus.csr_s), 32'h305);
    chk("ecall_npc", bus.npc, 32'h80000100);
    chk("ecall_rwen", 32'(bus.r_wen), 0);
    @(posedge clk); #1 chk("ecall_nohalt", 32'(bus.halt), 0);
    @(negedge clk); bus.csr_src = 32'h0000000F;
    drive(32'h300110F3, 32'h80000024, 32'h000000AA, 0);
    #1;
    chk("csrrw_s", 32'(bus.csr_s), 32'h300);
    chk("csrrw_d1", 32'(bus.csr_d1), 32'h300);
    chk("csrrw_wen1", 32'(bus.csr_wen1), 1);
    chk("csrrw_wd1", bus.csr_wdata1, 32'h000000AA);
    chk("csrrw_rwen", 32'(bus.r_wen), 1);
    chk("csrrw_wdata", bus.r_wdata, 32'h0000000F);
`else
    drive(INST_ECALL, 32'h80000020, 0, 0);
    #1;
    quiet("ecall");
    chk("ecall_npc", bus.npc, 32'h80000020);
    @(posedge clk); #1 chk("ecall_halt", 32'(bus.halt), 1);
    reset_pulse();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
